// File: rtl/rr_seq_pkg.sv
// Shared constants and FSM state codes for the rr_shift_seq sequencer.
package rr_seq_pkg;
  localparam int WORD_W    = 16;
  localparam int WORDS     = 16;
  localparam int CNT_W     = 9;
  localparam int MAX_SHIFT = 256;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;
endpackage

// File: rtl/rr_seq_cnt.sv
// Loadable down-counter with enable, sync clear and zero flag; holds at zero.
module rr_seq_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= din;
    else if (en && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rr_shift_seq.sv
// Word-serial sequencer for the 256-bit right-shift register: clear, load, shift, unload.
// Optional RR_SEQ_ZERO_FLAG_EN adds is_zero (all result words zero, valid with done).
module rr_shift_seq
  import rr_seq_pkg::*;
#(
  parameter int WORD_W = rr_seq_pkg::WORD_W,
  parameter int WORDS  = rr_seq_pkg::WORDS,
  parameter int CNT_W  = rr_seq_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  shift_num,
  input  logic              fill_bit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  input  logic [WORD_W-1:0] reg_regout,
  output logic              reg_we,
  output logic              reg_sel_rs,
  output logic              reg_clr,
  output logic              reg_bit256,
  output logic [WORD_W-1:0] reg_regin,
  output logic              busy,
`ifdef RR_SEQ_ZERO_FLAG_EN
  output logic              is_zero,
`endif
  output logic              done
);
  localparam int WC_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] MAXC  = CNT_W'(MAX_SHIFT);
  localparam logic [WC_W-1:0]  LASTW = WC_W'(WORDS - 1);

  logic [2:0]       state_q, state_d;
  logic             abort_q;
  logic [WC_W-1:0]  wcnt_q;
  logic             done_q;
  logic [CNT_W-1:0] n_sat, cnt;
  logic             cnt_zero;

  logic idle, st_load, st_shift, st_unload, kill, load_acc, out_acc, last_w;

  assign idle      = (state_q == ST_IDLE);
  assign st_load   = (state_q == ST_LOAD);
  assign st_shift  = (state_q == ST_SHIFT);
  assign st_unload = (state_q == ST_UNLOAD);
  assign kill      = !idle && abort;
  assign load_acc  = st_load && in_valid && !abort;
  assign out_acc   = st_unload && out_ready && !abort;
  assign last_w    = (wcnt_q == LASTW);
  assign n_sat     = (shift_num > MAXC) ? MAXC : shift_num;

  rr_seq_cnt #(.W(CNT_W)) u_shcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (kill),
    .load  (idle && start),
    .din   (n_sat),
    .en    (st_shift && !abort),
    .cnt   (cnt),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLR;
      // a CLR reached through abort drains straight back to IDLE
      ST_CLR:    state_d = abort_q ? ST_IDLE : ST_LOAD;
      ST_LOAD:   if (load_acc && last_w) state_d = cnt_zero ? ST_UNLOAD : ST_SHIFT;
      ST_SHIFT:  if (cnt == CNT_W'(1)) state_d = ST_UNLOAD;
      ST_UNLOAD: if (out_acc && last_w) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_CLR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= kill;
      done_q  <= out_acc && last_w;
      if (kill)                     wcnt_q <= '0;
      else if (load_acc || out_acc) wcnt_q <= last_w ? '0 : wcnt_q + WC_W'(1);
    end
  end

`ifdef RR_SEQ_ZERO_FLAG_EN
  logic zacc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_q  <= 1'b0;
      is_zero <= 1'b0;
    end else begin
      if (idle && start)  zacc_q <= 1'b1;
      else if (out_acc)   zacc_q <= zacc_q && (reg_regout == '0);
      is_zero <= out_acc && last_w && zacc_q && (reg_regout == '0);
    end
  end
`endif

  // handshake readies are state-only; reg_we follows the partner's valid/ready
  assign busy       = !idle;
  assign done       = done_q;
  assign in_ready   = st_load;
  assign out_valid  = st_unload;
  assign out_data   = st_unload ? reg_regout : '0;
  assign reg_clr    = (state_q == ST_CLR);
  assign reg_sel_rs = st_shift;
  assign reg_bit256 = st_shift && fill_bit;
  assign reg_regin  = st_load ? in_data : '0;
  assign reg_we     = ((st_load && in_valid) || st_shift || (st_unload && out_ready)) && !abort;
endmodule
